// File: rtl/filtered_line_pingpong_pkg.sv
// Shared state encoding and helpers for the filtered projection line ping-pong buffer.
package filtered_line_pingpong_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_DELAY = 2'd1,
    ST_FILL  = 2'd2,
    ST_FULL  = 2'd3
  } line_state_e;

  function automatic int last_addr(input int line_size);
    return line_size - 1;
  endfunction

endpackage

// File: rtl/filtered_line_ram.sv
// Single-write, single-read synchronous line RAM with a registered read port.
module filtered_line_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int A_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [A_W-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [A_W-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/filtered_line_pingpong.sv
// Double-buffered filtered line store: the host fills one bank while NUM_PR
// processing channels read the other; banks swap on a processing handshake.
module filtered_line_pingpong
  import filtered_line_pingpong_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int LINE_SIZE    = 256,
  parameter int S_W          = $clog2(LINE_SIZE + 1) + 1,
  parameter int FILTER_DELAY = 8,
  parameter int NUM_PR       = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     hs_fill_kick,
  input  logic [DATA_W-1:0]        hs_val,
  output logic [S_W-1:0]           hs_s_val,
  output logic                     hs_ready,
  output logic                     hs_fill_done,
  input  logic                     pr_swap,
  output logic                     pr_line_valid,
  input  logic [NUM_PR*S_W-1:0]    pr_s_val,
  output logic [NUM_PR*DATA_W-1:0] pr_val
);

  localparam int                A_W        = $clog2(LINE_SIZE);
  localparam int                LAST_ADDR  = last_addr(LINE_SIZE);
  localparam logic [S_W-1:0]    ZERO_S     = '0;
  localparam logic [DATA_W-1:0] ZERO_V     = '0;
  localparam logic [S_W-1:0]    ONE_S      = S_W'(1);
  localparam logic [A_W-1:0]    ONE_A      = A_W'(1);
  localparam logic [A_W-1:0]    LAST_A     = A_W'(LAST_ADDR);
  localparam logic [S_W-1:0]    LINE_S     = S_W'(LINE_SIZE);
  localparam logic [S_W-1:0]    DELAY_LAST = S_W'(FILTER_DELAY - 1);

  line_state_e      state;
  logic [S_W-1:0]   read_itr;
  logic [A_W-1:0]   write_itr;
  logic             active;
  logic [1:0]       fill_we;
  logic             sel_q;
  logic [NUM_PR-1:0] in_range;
  logic [NUM_PR-1:0] in_range_q;
  logic [DATA_W-1:0] rd_data [2][NUM_PR];

  assign hs_s_val     = read_itr;
  assign hs_ready     = (state == ST_READY);
  assign hs_fill_done = (state == ST_FILL) && (write_itr == LAST_A);
  assign fill_we[0]   = (state == ST_FILL) && active;
  assign fill_we[1]   = (state == ST_FILL) && !active;

  // A swap request always releases the current line; publishing a new line in FULL overrides that.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_READY;
      read_itr      <= ZERO_S;
      write_itr     <= '0;
      active        <= 1'b0;
      pr_line_valid <= 1'b0;
    end else begin
      if (pr_swap) pr_line_valid <= 1'b0;
      case (state)
        ST_READY: begin
          if (hs_fill_kick) begin
            read_itr  <= ZERO_S;
            write_itr <= '0;
            state     <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          read_itr <= read_itr + ONE_S;
          if (read_itr == DELAY_LAST) state <= ST_FILL;
        end
        ST_FILL: begin
          write_itr <= write_itr + ONE_A;
          if (read_itr < LINE_S) read_itr <= read_itr + ONE_S;
          if (write_itr == LAST_A) state <= ST_FULL;
        end
        ST_FULL: begin
          if (!pr_line_valid || pr_swap) begin
            active        <= ~active;
            pr_line_valid <= 1'b1;
            state         <= ST_READY;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Bank select and range flag travel with the RAM read so a same-cycle swap only affects later addresses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= 1'b0;
      in_range_q <= '0;
    end else begin
      sel_q      <= active;
      in_range_q <= in_range;
    end
  end

  for (genvar i = 0; i < NUM_PR; i++) begin : g_lane
    logic [S_W-1:0] lane_addr;
    logic           lane_in_range;
    logic [A_W-1:0] lane_raddr;

    assign lane_addr     = pr_s_val[i*S_W +: S_W];
    assign lane_in_range = !lane_addr[S_W-1] && (lane_addr < LINE_S);
    assign lane_raddr    = lane_in_range ? lane_addr[A_W-1:0] : '0;
    assign in_range[i]   = lane_in_range;

    for (genvar b = 0; b < 2; b++) begin : g_bank
      filtered_line_ram #(
        .DEPTH(LINE_SIZE),
        .WIDTH(DATA_W)
      ) u_ram (
        .clk  (clk),
        .we   (fill_we[b]),
        .waddr(write_itr),
        .wdata(hs_val),
        .raddr(lane_raddr),
        .rdata(rd_data[b][i])
      );
    end

    assign pr_val[i*DATA_W +: DATA_W] = in_range_q[i] ? rd_data[sel_q][i] : ZERO_V;
  end

endmodule

// File: tb/tb_filtered_line_pingpong.sv
// Self-checking bench: directed fill/swap/reset sequences, a read-vector table,
// and randomized traffic checked against a line-level reference model.
module tb_filtered_line_pingpong;

  localparam int DATA_W = 16;
  localparam int LS     = 16;
  localparam int FD     = 4;
  localparam int NPR    = 4;
  localparam int S_W    = $clog2(LS + 1) + 1;
  localparam int NV     = 3;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  hs_fill_kick = 1'b0;
  logic                  pr_swap = 1'b0;
  logic [DATA_W-1:0]     hs_val = '0;
  logic [S_W-1:0]        hs_s_val;
  logic                  hs_ready;
  logic                  hs_fill_done;
  logic                  pr_line_valid;
  logic [NPR*S_W-1:0]    pr_s_val = '0;
  logic [NPR*DATA_W-1:0] pr_val;

  always #5 clk = ~clk;

  filtered_line_pingpong #(
    .DATA_W(DATA_W),
    .LINE_SIZE(LS),
    .FILTER_DELAY(FD),
    .NUM_PR(NPR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hs_fill_kick(hs_fill_kick),
    .hs_val(hs_val),
    .hs_s_val(hs_s_val),
    .hs_ready(hs_ready),
    .hs_fill_done(hs_fill_done),
    .pr_swap(pr_swap),
    .pr_line_valid(pr_line_valid),
    .pr_s_val(pr_s_val),
    .pr_val(pr_val)
  );

  typedef struct packed {
    logic [NPR-1:0][7:0]  a;
    logic [NPR-1:0][15:0] v;
  } read_vec_t;

  read_vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int kick_cyc;
  int done_cyc;

  // Line-level model: cycles since an accepted kick, a finished line awaiting publish, bank images.
  int since_kick;
  bit pending;
  bit valid;
  int act;
  int last_s;
  int fill_base;
  int bank [2][LS];
  bit known [2][LS];
  int exp_pv [NPR];
  bit exp_known [NPR];
  int addr [NPR];

  function automatic read_vec_t mkvec(input int a0, a1, a2, a3, v0, v1, v2, v3);
    read_vec_t r;
    r.a[0] = a0[7:0]; r.a[1] = a1[7:0]; r.a[2] = a2[7:0]; r.a[3] = a3[7:0];
    r.v[0] = v0[15:0]; r.v[1] = v1[15:0]; r.v[2] = v2[15:0]; r.v[3] = v3[15:0];
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    since_kick = -1;
    pending    = 1'b0;
    valid      = 1'b0;
    act        = 0;
    last_s     = 0;
    for (int i = 0; i < NPR; i++) begin
      exp_pv[i]    = 0;
      exp_known[i] = 1'b1;
    end
  endtask

  // Called at posedge+1; reset is asserted immediately and released one edge later.
  task automatic doReset();
    hs_fill_kick = 1'b0;
    pr_swap      = 1'b0;
    reset_n      = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_hs_ready", hs_ready, 1);
    checkOutput("rst_line_valid", pr_line_valid, 0);
    checkOutput("rst_fill_done", hs_fill_done, 0);
    checkOutput("rst_hs_s_val", hs_s_val, 0);
    for (int i = 0; i < NPR; i++)
      checkOutput($sformatf("rst_pr_val%0d", i), pr_val[i*DATA_W +: DATA_W], 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input bit kick, input bit swap);
    int  widx;
    int  exp_s;
    bit  idle;
    @(negedge clk);
    exp_s = (since_kick >= 1) ? ((since_kick - 1 < LS) ? since_kick - 1 : LS) : last_s;
    checkOutput("hs_ready", hs_ready, (since_kick < 0) && !pending);
    checkOutput("hs_s_val", hs_s_val, exp_s);
    checkOutput("hs_fill_done", hs_fill_done, since_kick == FD + LS);
    checkOutput("pr_line_valid", pr_line_valid, valid);
    for (int i = 0; i < NPR; i++)
      if (exp_known[i])
        checkOutput($sformatf("pr_val%0d", i), pr_val[i*DATA_W +: DATA_W], exp_pv[i]);
    if (hs_fill_done) done_cyc = cyc;

    widx = since_kick - FD - 1;
    hs_val = (widx >= 0 && widx < LS) ? 16'(fill_base + widx) : 16'hDEAD;
    hs_fill_kick = kick;
    pr_swap = swap;
    for (int i = 0; i < NPR; i++) pr_s_val[i*S_W +: S_W] = S_W'(addr[i]);

    for (int i = 0; i < NPR; i++) begin
      if (addr[i] >= 0 && addr[i] < LS) begin
        exp_pv[i]    = bank[act][addr[i]];
        exp_known[i] = known[act][addr[i]];
      end else begin
        exp_pv[i]    = 0;
        exp_known[i] = 1'b1;
      end
    end
    idle = (since_kick < 0) && !pending;
    if (widx >= 0 && widx < LS) begin
      bank[1-act][widx]  = int'(hs_val);
      known[1-act][widx] = 1'b1;
    end
    if (pending) begin
      if (!valid || swap) begin
        act     = 1 - act;
        valid   = 1'b1;
        pending = 1'b0;
      end
    end else if (swap) begin
      valid = 1'b0;
    end
    if (since_kick == FD + LS) begin
      since_kick = -1;
      pending    = 1'b1;
      last_s     = LS;
    end else if (since_kick > 0) begin
      since_kick++;
    end else if (idle && kick) begin
      since_kick = 1;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTable();
    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < NPR; i++) addr[i] = int'($signed(vecs[v].a[i]));
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < NPR; i++)
        checkOutput($sformatf("table%0d_lane%0d", v, i), pr_val[i*DATA_W +: DATA_W], vecs[v].v[i]);
    end
  endtask

  task automatic fillLine(input int base, input bit noisy_kicks);
    fill_base = base;
    done_cyc  = -1;
    kick_cyc  = cyc;
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < FD + LS; k++) begin
      if (noisy_kicks)
        for (int i = 0; i < NPR; i++) addr[i] = int'($urandom_range(0, LS - 1));
      applyStimulus(noisy_kicks && (k == 1 || k == FD + 3), 1'b0);
    end
    checkOutput("done_latency", done_cyc - kick_cyc, FD + LS);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = mkvec(5, 15, -1, 16, 105, 115, 0, 0);
    vecs[1] = mkvec(0, 3, 8, 15, 100, 103, 108, 115);
    vecs[2] = mkvec(-32, 31, 14, 1, 0, 0, 114, 101);
    for (int i = 0; i < NPR; i++) addr[i] = -1;

    doReset();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // First line: DELAY walk, fill, publish into bank 1.
    fillLine(100, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("valid_after_first_fill", pr_line_valid, 1);
    runTable();

    // Second line fills while line 1 is being read; stray kicks must be ignored.
    fillLine(200, 1'b1);
    for (int i = 0; i < NPR; i++) addr[i] = 5;
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("full_holds", hs_ready, 0);
    checkOutput("old_line_during_hold", pr_val[15:0], 105);
    applyStimulus(1'b0, 1'b1);
    checkOutput("read_in_swap_cycle", pr_val[15:0], 105);
    applyStimulus(1'b0, 1'b0);
    checkOutput("read_after_swap", pr_val[15:0], 205);
    checkOutput("valid_after_swap", pr_line_valid, 1);

    // Kick and release together in READY, then reset in the middle of the fill.
    fill_base = 300;
    applyStimulus(1'b1, 1'b1);
    checkOutput("kick_swap_valid", pr_line_valid, 0);
    checkOutput("kick_swap_busy", hs_ready, 0);
    repeat (FD + 7) applyStimulus(1'b0, 1'b0);
    doReset();
    for (int i = 0; i < NPR; i++) addr[i] = -1;
    applyStimulus(1'b0, 1'b0);
    fillLine(100, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("valid_after_refill", pr_line_valid, 1);
    runTable();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NPR; i++) addr[i] = int'($urandom_range(0, LS + 7)) - 4;
      if (since_kick < 0 && !pending) fill_base = int'($urandom_range(0, 65535));
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
